param_seq_alu: RTL

PARAM_SEQ_ALU -- requirements
Module: param_seq_alu

---
 rtl/param_seq_alu.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/param_seq_alu.sv
// Sequential signed ALU. Single-cycle ops (arithmetic, logic, shift,
// compare, divide-by-zero, illegal opcode) finish on the accepting edge.
// MUL and DIV run N shift-add / restoring iterations on operand magnitudes,
// then a sign-fix cycle. All outputs are registered and held between done
// pulses.
module param_seq_alu #(
  parameter int N  = 16,
  parameter int SW = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [3:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic [N-1:0] result_hi,
  output logic         zero_flag,
  output logic         sign_flag,
  output logic         overflow,
  output logic         dbz_flag
);

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_DIV = 4'd2,  OP_AND = 4'd3,
    OP_OR  = 4'd4,  OP_XOR = 4'd5,  OP_NOR = 4'd6,  OP_LSL = 4'd7,
    OP_LSR = 4'd8,  OP_ASR = 4'd9,  OP_EQ  = 4'd10, OP_GT  = 4'd11,
    OP_LT  = 4'd12, OP_MUL = 4'd13
  } op_e;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_e;

  localparam int CW = $clog2(N);

  state_e         state;
  logic [CW-1:0]  cnt;
  logic           is_mul;
  logic           neg_q;      // quotient / product must be negated
  logic           neg_r;      // remainder must be negated (dividend sign)
  logic           div_ovf;    // most-negative / -1 case
  logic [N-1:0]   mc;         // |b|: multiplicand or divisor
  logic [N:0]     acc_hi;     // product high half / partial remainder
  logic [N-1:0]   acc_lo;     // multiplier bits / dividend bits -> quotient

  op_e            op_c;
  logic [SW-1:0]  sh;
  logic           long_op;
  logic [N-1:0]   a_mag, b_mag;

  // single-cycle datapath outputs
  logic [N-1:0]   s_res, s_hi;
  logic           s_ov, s_dbz, s_cmp;

  // iteration and sign-fix datapath
  logic [N:0]     mul_sum, div_shift, div_diff;
  logic           div_ok;
  logic [2*N-1:0] mul_mag, mul_prod;
  logic [N-1:0]   quo, rem;
  logic [N-1:0]   f_res, f_hi;
  logic           f_ov;

  assign op_c    = op_e'(op);
  assign sh      = b[SW-1:0];
  assign long_op = (op_c == OP_MUL) || ((op_c == OP_DIV) && (b != '0));
  assign a_mag   = a[N-1] ? -a : a;
  assign b_mag   = b[N-1] ? -b : b;

  // Combinational result of every operation that completes on the accepting edge.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
  always_comb begin
    s_res = '0;
    s_hi  = '0;
    s_ov  = 1'b0;
    s_dbz = 1'b0;
    s_cmp = 1'b0;
    case (op_c)
      OP_ADD: begin
        s_res = a + b;
        s_ov  = (a[N-1] == b[N-1]) && (s_res[N-1] != a[N-1]);
      end
      OP_SUB: begin
        s_res = a - b;
        s_ov  = (a[N-1] != b[N-1]) && (s_res[N-1] != a[N-1]);
      end
      OP_DIV: begin
        // Only the divide-by-zero case reaches this path.
        s_hi  = a;
        s_dbz = 1'b1;
      end
      OP_AND: s_res = a & b;
      OP_OR:  s_res = a | b;
      OP_XOR: s_res = a ^ b;
      OP_NOR: s_res = ~(a | b);
      OP_LSL: s_res = a << sh;
      OP_LSR: s_res = a >> sh;
      OP_ASR: s_res = $signed(a) >>> sh;
      OP_EQ: begin
        s_res = {{(N-1){1'b0}}, (a == b)};
        s_cmp = 1'b1;
      end
      OP_GT: begin
        s_res = {{(N-1){1'b0}}, ($signed(a) > $signed(b))};
        s_cmp = 1'b1;
      end
      OP_LT: begin
        s_res = {{(N-1){1'b0}}, ($signed(a) < $signed(b))};
        s_cmp = 1'b1;
      end
      OP_MUL: ;  // always takes the iterative path
      default: ; // illegal opcode: all-zero result, zero_flag follows
    endcase
  end

  // One shift-add or restoring-divide step, and the final sign correction.
  always_comb begin
    mul_sum   = acc_hi + (acc_lo[0] ? {1'b0, mc} : '0);
    div_shift = {acc_hi[N-1:0], acc_lo[N-1]};
    div_diff  = div_shift - {1'b0, mc};
    div_ok    = ~div_diff[N];

    mul_mag   = {acc_hi[N-1:0], acc_lo};
    mul_prod  = neg_q ? -mul_mag : mul_mag;
    quo       = neg_q ? -acc_lo : acc_lo;
    rem       = neg_r ? -acc_hi[N-1:0] : acc_hi[N-1:0];

    if (is_mul) begin
      f_res = mul_prod[N-1:0];
      f_hi  = mul_prod[2*N-1:N];
      // Representable in N signed bits only if the top N+1 bits are a sign run.
      f_ov  = (mul_prod[2*N-1:N-1] != '0) && (mul_prod[2*N-1:N-1] != '1);
    end else begin
      f_res = quo;
      f_hi  = rem;
      f_ov  = div_ovf;
    end
  end

  // Control FSM, iteration registers and registered outputs.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      is_mul    <= 1'b0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      div_ovf   <= 1'b0;
      mc        <= '0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      result_hi <= '0;
      zero_flag <= 1'b0;
      sign_flag <= 1'b0;
      overflow  <= 1'b0;
      dbz_flag  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          state <= S_IDLE;
          if (start && !busy) begin
            if (long_op) begin
              is_mul  <= (op_c == OP_MUL);
              neg_q   <= a[N-1] ^ b[N-1];
              neg_r   <= a[N-1];
              div_ovf <= (op_c == OP_DIV) && (a == {1'b1, {(N-1){1'b0}}}) && (b == '1);
              mc      <= b_mag;
              acc_hi  <= '0;
              acc_lo  <= a_mag;
              cnt     <= '0;
              busy    <= 1'b1;
              state   <= S_CALC;
            end else begin
              result    <= s_res;
              result_hi <= s_hi;
              zero_flag <= (s_res == '0);
              sign_flag <= s_cmp ? 1'b0 : s_res[N-1];
              overflow  <= s_ov;
              dbz_flag  <= s_dbz;
              done      <= 1'b1;
              state     <= S_DONE;
            end
          end
        end
        S_CALC: begin
          if (is_mul) begin
            acc_hi <= {1'b0, mul_sum[N:1]};
            acc_lo <= {mul_sum[0], acc_lo[N-1:1]};
          end else begin
            acc_hi <= div_ok ? div_diff : div_shift;
            acc_lo <= {acc_lo[N-2:0], div_ok};
          end
          cnt <= cnt + 1'b1;
          if (cnt == CW'(N-1)) state <= S_FIX;
        end
        S_FIX: begin
          result    <= f_res;
          result_hi <= f_hi;
          zero_flag <= (f_res == '0);
          sign_flag <= f_res[N-1];
          overflow  <= f_ov;
          dbz_flag  <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b1;
          state     <= S_DONE;
        end
      endcase
    end
  end

endmodule
